branch_resolve_queue: RTL

In-order tracker for branches in flight between fetch and execute, sitting directly upstream of the 2-bit/global-history branch predictor. It issues `request` to the predictor for each fetched branch and captures the returned prediction with the branch PC. When execute resolves the oldest branch, it drives the predictor's `result`/`taken` update, detects mispredictions, and issues a registered redirect that flushes younger entries.

---
 rtl/brq_pkg.sv | 14 +
 rtl/brq_if.sv | 50 +++++
 rtl/brq_fifo.sv | 63 ++++++
 rtl/branch_resolve_queue.sv | 119 +++++++++++
 4 files changed

// File: rtl/brq_pkg.sv
// Shared types and constants for the branch resolve queue.
// The BRQ_STATS_EN build option is handled in the interface and top files.
package brq_pkg;

  localparam int BRQ_PC_W       = 32;
  localparam int BRQ_INSN_BYTES = 4;

  typedef struct packed {
    logic [BRQ_PC_W-1:0] pc;
    logic                pred;
    logic                pending;
  } brq_entry_t;

endpackage

// File: rtl/brq_if.sv
// Bundle of the fetch, predictor and execute signals around the branch resolve queue.
// Defining BRQ_STATS_EN adds the statistics counter outputs.
interface brq_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = brq_pkg::BRQ_PC_W
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             fe_valid;
  logic [PC_W-1:0]  fe_pc;
  logic             fe_ready;
  logic             fe_pred_valid;
  logic             fe_pred_taken;
  logic             pred_request;
  logic             pred_prediction;
  logic             pred_result;
  logic             pred_taken;
  logic             ex_valid;
  logic             ex_taken;
  logic [PC_W-1:0]  ex_target;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] count;
  logic             underflow;
`ifdef BRQ_STATS_EN
  logic [15:0]      stat_branches;
  logic [15:0]      stat_mispredicts;
`endif

  // The queue itself is the slave; fetch/predictor/execute collectively form the master.
  modport slave (
    input  fe_valid, fe_pc, pred_prediction, ex_valid, ex_taken, ex_target,
    output fe_ready, fe_pred_valid, fe_pred_taken, pred_request, pred_result,
           pred_taken, mispredict, redirect_pc, count, underflow
`ifdef BRQ_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );

  modport master (
    output fe_valid, fe_pc, pred_prediction, ex_valid, ex_taken, ex_target,
    input  fe_ready, fe_pred_valid, fe_pred_taken, pred_request, pred_result,
           pred_taken, mispredict, redirect_pc, count, underflow
`ifdef BRQ_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );

endinterface

// File: rtl/brq_fifo.sv
// Circular entry store for in-flight branches: push at tail, pop at head,
// whole-queue flush, and a late write of the prediction bit into one slot.
module brq_fifo
  import brq_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int PC_W  = BRQ_PC_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [PC_W-1:0]  pushPc_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic             predWe_i,
  input  logic [PTR_W-1:0] predIdx_i,
  input  logic             pred_i,
  output brq_entry_t       head_o,
  output logic [PTR_W-1:0] tail_o,
  output logic [CNT_W-1:0] count_o
);

  brq_entry_t       entries_q [DEPTH];
  logic [PTR_W-1:0] headPtr_q;
  logic [PTR_W-1:0] tailPtr_q;
  logic [CNT_W-1:0] count_q;

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else if (flush_i) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i].pending <= 1'b0;
    end else begin
      if (predWe_i) begin
        entries_q[predIdx_i].pred    <= pred_i;
        entries_q[predIdx_i].pending <= 1'b0;
      end
      if (push_i) begin
        entries_q[tailPtr_q].pc      <= BRQ_PC_W'(pushPc_i);
        entries_q[tailPtr_q].pred    <= 1'b0;
        entries_q[tailPtr_q].pending <= 1'b1;
        tailPtr_q                    <= tailPtr_q + PTR_W'(1);
      end
      if (pop_i) headPtr_q <= headPtr_q + PTR_W'(1);
      if (push_i && !pop_i)      count_q <= count_q + CNT_W'(1);
      else if (pop_i && !push_i) count_q <= count_q - CNT_W'(1);
    end
  end

  assign head_o  = entries_q[headPtr_q];
  assign tail_o  = tailPtr_q;
  assign count_o = count_q;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order tracker of fetched branches awaiting resolution; feeds the predictor and
// raises a registered redirect on mispredict. BRQ_STATS_EN adds resolve/mispredict counters.
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int PC_W  = BRQ_PC_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  brq_if.slave bus
);

  brq_entry_t       head;
  logic [PTR_W-1:0] tailPtr;
  logic [CNT_W-1:0] count;
  logic [PC_W-1:0]  headPc;
  logic             accept;
  logic             resolve;
  logic             headPred;
  logic             mismatch;

  logic             capValid_q,   capValid_d;
  logic [PTR_W-1:0] capPtr_q,     capPtr_d;
  logic             mispredict_q, mispredict_d;
  logic [PC_W-1:0]  redirectPc_q, redirectPc_d;
  logic             underflow_q,  underflow_d;
`ifdef BRQ_STATS_EN
  logic [15:0]      statBranches_q,    statBranches_d;
  logic [15:0]      statMispredicts_q, statMispredicts_d;
`endif

  assign accept   = bus.fe_valid && bus.fe_ready;
  assign resolve  = bus.ex_valid && (count != '0);
  assign headPc   = PC_W'(head.pc);
  // A head still waiting on its prediction takes it straight from the predictor.
  assign headPred = head.pending ? bus.pred_prediction : head.pred;
  assign mismatch = resolve && (headPred != bus.ex_taken);

  brq_fifo #(
    .DEPTH(DEPTH),
    .PC_W (PC_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (accept && !mismatch),
    .pushPc_i (bus.fe_pc),
    .pop_i    (resolve && !mismatch),
    .flush_i  (mismatch),
    .predWe_i (capValid_q),
    .predIdx_i(capPtr_q),
    .pred_i   (bus.pred_prediction),
    .head_o   (head),
    .tail_o   (tailPtr),
    .count_o  (count)
  );

  always_comb begin
    capValid_d   = accept && !mismatch;
    capPtr_d     = accept ? tailPtr : capPtr_q;
    mispredict_d = mismatch;
    redirectPc_d = redirectPc_q;
    underflow_d  = underflow_q;
    if (mismatch)
      redirectPc_d = bus.ex_taken ? bus.ex_target : headPc + PC_W'(BRQ_INSN_BYTES);
    if (bus.ex_valid && (count == '0))
      underflow_d = 1'b1;
`ifdef BRQ_STATS_EN
    statBranches_d    = statBranches_q;
    statMispredicts_d = statMispredicts_q;
    if (resolve && (statBranches_q != 16'hFFFF))
      statBranches_d = statBranches_q + 16'd1;
    if (mismatch && (statMispredicts_q != 16'hFFFF))
      statMispredicts_d = statMispredicts_q + 16'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capValid_q   <= 1'b0;
      capPtr_q     <= '0;
      mispredict_q <= 1'b0;
      redirectPc_q <= '0;
      underflow_q  <= 1'b0;
`ifdef BRQ_STATS_EN
      statBranches_q    <= '0;
      statMispredicts_q <= '0;
`endif
    end else begin
      capValid_q   <= capValid_d;
      capPtr_q     <= capPtr_d;
      mispredict_q <= mispredict_d;
      redirectPc_q <= redirectPc_d;
      underflow_q  <= underflow_d;
`ifdef BRQ_STATS_EN
      statBranches_q    <= statBranches_d;
      statMispredicts_q <= statMispredicts_d;
`endif
    end
  end

  assign bus.fe_ready      = count < CNT_W'(DEPTH);
  assign bus.pred_request  = accept;
  assign bus.fe_pred_valid = capValid_q;
  assign bus.fe_pred_taken = capValid_q && bus.pred_prediction;
  assign bus.pred_result   = resolve;
  assign bus.pred_taken    = bus.ex_taken;
  assign bus.mispredict    = mispredict_q;
  assign bus.redirect_pc   = redirectPc_q;
  assign bus.count         = count;
  assign bus.underflow     = underflow_q;
`ifdef BRQ_STATS_EN
  assign bus.stat_branches    = statBranches_q;
  assign bus.stat_mispredicts = statMispredicts_q;
`endif

endmodule
